// File: rtl/timer_scheduler_if.sv
// Timer register port: strobes, address and write data driven by the scheduler;
// combinational read data, ready and registered write error returned by the timer.
interface timer_scheduler_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) ();
    logic                  t_rd_en;
    logic                  t_wr_en;
    logic [ADDR_WIDTH-1:0] t_addr;
    logic [DATA_WIDTH-1:0] t_wr_data;
    logic [DATA_WIDTH-1:0] t_rd_data;
    logic                  t_ready;
    logic                  t_error;

    modport master (
        output t_rd_en, t_wr_en, t_addr, t_wr_data,
        input  t_rd_data, t_ready, t_error
    );

    modport slave (
        input  t_rd_en, t_wr_en, t_addr, t_wr_data,
        output t_rd_data, t_ready, t_error
    );
endinterface

// File: rtl/timer_scheduler.sv
// Timer scheduler: programs a memory-mapped timer (stop, enable, load), polls
// its status for expiry, reloads for repeated expiries and disarms at the end.
// Every output is a register loaded from the next state, so nothing on the
// timer port or status outputs depends combinationally on an input.
module timer_scheduler #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] TIMER_BASE = 'h4000_0000,
    parameter int                    SETTLE     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] period,
    input  logic [15:0]           reps,
    output logic                  busy,
    output logic                  tick,
    output logic                  done,
    output logic                  err,
    output logic [15:0]           rep_cnt,
    timer_scheduler_if.master     tmr
);

    localparam logic [ADDR_WIDTH-1:0] A_CTRL   = TIMER_BASE;
    localparam logic [ADDR_WIDTH-1:0] A_LOAD   = TIMER_BASE + ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] A_STATUS = TIMER_BASE + ADDR_WIDTH'(20);
    localparam int                    SCW      = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_STOP, S_ENABLE, S_LOAD, S_SETTLE, S_POLL, S_DISARM, S_FINISH
    } state_t;

    state_t                state, nxt;
    logic [DATA_WIDTH-1:0] period_q;
    logic [15:0]           reps_q;
    logic [SCW-1:0]        settle_cnt;
    logic                  wr_pend;     // previous cycle carried a STOP/ENABLE/LOAD write
    logic                  accept;
    logic                  active;
    logic                  expire;
    logic                  wr_fault;
    logic                  tick_set;

    // Only bit 0 of the status word carries meaning.
    logic unused_rd_bits;
    assign unused_rd_bits = ^tmr.t_rd_data[DATA_WIDTH-1:1];

    // Next-state decode; abort and write faults override the normal flow.
    always_comb begin
        nxt      = state;
        accept   = 1'b0;
        active   = state inside {S_STOP, S_ENABLE, S_LOAD, S_SETTLE, S_POLL};
        expire   = (state == S_POLL) && tmr.t_ready && tmr.t_rd_data[0];
        wr_fault = wr_pend && tmr.t_error;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    nxt    = S_STOP;
                    accept = 1'b1;
                end
            end
            S_STOP:   nxt = S_ENABLE;
            S_ENABLE: nxt = S_LOAD;
            S_LOAD:   nxt = (SETTLE == 0) ? S_POLL : S_SETTLE;
            S_SETTLE: if (settle_cnt == '0) nxt = S_POLL;
            S_POLL: begin
                if (expire)
                    nxt = (reps_q != 16'd0 && rep_cnt + 16'd1 == reps_q) ? S_DISARM : S_LOAD;
            end
            S_DISARM: nxt = S_FINISH;
            S_FINISH: nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
        if (active && (abort || wr_fault))
            nxt = S_DISARM;
        tick_set = expire && !abort && !wr_fault;
    end

    // State, latched command, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            period_q      <= '0;
            reps_q        <= '0;
            settle_cnt    <= '0;
            wr_pend       <= 1'b0;
            busy          <= 1'b0;
            tick          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            rep_cnt       <= '0;
            tmr.t_rd_en   <= 1'b0;
            tmr.t_wr_en   <= 1'b0;
            tmr.t_addr    <= '0;
            tmr.t_wr_data <= '0;
        end else begin
            state   <= nxt;
            wr_pend <= state inside {S_STOP, S_ENABLE, S_LOAD};
            busy    <= (nxt != S_IDLE);
            tick    <= tick_set;
            done    <= (nxt == S_FINISH);

            if (accept) begin
                // Loads of 0 or 1 would expire immediately; run them as 2.
                period_q <= (period < DATA_WIDTH'(2)) ? DATA_WIDTH'(2) : period;
                reps_q   <= reps;
                rep_cnt  <= '0;
                err      <= 1'b0;
            end else begin
                if (tick_set && rep_cnt != 16'hFFFF)
                    rep_cnt <= rep_cnt + 16'd1;
                if (wr_fault)
                    err <= 1'b1;
            end

            if (nxt == S_SETTLE && state != S_SETTLE)
                settle_cnt <= SCW'(SETTLE - 1);
            else if (state == S_SETTLE && settle_cnt != '0)
                settle_cnt <= settle_cnt - 1'b1;

            tmr.t_wr_en   <= nxt inside {S_STOP, S_ENABLE, S_LOAD, S_DISARM};
            tmr.t_rd_en   <= (nxt == S_POLL);
            tmr.t_wr_data <= (nxt == S_ENABLE) ? DATA_WIDTH'(1) :
                             (nxt == S_LOAD)   ? period_q       : '0;
            case (nxt)
                S_STOP, S_ENABLE, S_SETTLE, S_DISARM: tmr.t_addr <= A_CTRL;
                S_LOAD:                               tmr.t_addr <= A_LOAD;
                S_POLL:                               tmr.t_addr <= A_STATUS;
                default:                              tmr.t_addr <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_scheduler.sv
// Self-checking bench for timer_scheduler: a behavioural down-counting timer
// answers the register port, a monitor records writes/ticks/dones, and each
// scenario compares against the write sequence the schedule rules imply.
module tb_timer_scheduler;
    localparam int          DW     = 32;
    localparam int          AW     = 32;
    localparam int          SETTLE = 3;
    localparam logic [31:0] BASE   = 32'h4000_0000;
    localparam logic [31:0] A_CTRL = BASE;
    localparam logic [31:0] A_LOAD = BASE + 32'h4;
    localparam logic [31:0] A_STAT = BASE + 32'h14;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] period = '0;
    logic [15:0] reps = '0;
    logic        busy, tick, done, err;
    logic [15:0] rep_cnt;

    timer_scheduler_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    timer_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMER_BASE(BASE), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .period(period), .reps(reps),
        .busy(busy), .tick(tick), .done(done), .err(err), .rep_cnt(rep_cnt), .tmr(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural timer: CTRL bit0 enables, LOAD sets the count, status bit0
    // rises when the count runs out and clears when read with ready high.
    logic [31:0] tcnt    = '0;
    logic        ten     = 1'b0;
    logic        expired = 1'b0;
    logic        terr    = 1'b0;
    logic        inj_en  = 1'b0;
    logic        rdy_rand = 1'b0;

    assign bus.t_rd_data = {31'b0, expired};
    assign bus.t_error   = terr;

    always @(posedge clk) begin
        terr <= inj_en && bus.t_wr_en && bus.t_addr == A_CTRL && bus.t_wr_data == 32'd1;
        if (bus.t_wr_en && bus.t_addr == A_LOAD) begin
            tcnt    <= bus.t_wr_data;
            expired <= 1'b0;
        end else if (bus.t_wr_en && bus.t_addr == A_CTRL) begin
            ten     <= bus.t_wr_data[0];
            expired <= 1'b0;
        end else begin
            if (ten && tcnt != 0) begin
                tcnt <= tcnt - 1;
                if (tcnt == 1) expired <= 1'b1;
            end
            if (bus.t_rd_en && bus.t_ready && expired) expired <= 1'b0;
        end
    end

    always @(negedge clk) bus.t_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;

    // Monitor: one sample per cycle, away from the active edge.
    wr_t wq[$];
    wr_t eq[$];
    int  n_tick = 0;
    int  n_done = 0;
    bit  both_seen = 0;

    always @(negedge clk) begin
        if (bus.t_wr_en) wq.push_back('{a: bus.t_addr, d: bus.t_wr_data});
        if (tick) n_tick++;
        if (done) n_done++;
        if (bus.t_wr_en && bus.t_rd_en) both_seen = 1;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clr_mon();
        wq.delete();
        n_tick = 0;
        n_done = 0;
    endtask

    // Expected writes: stop, enable, n_loads loads of the clamped period, disarm.
    task automatic build_exp(input logic [31:0] p, input int n_loads);
        logic [31:0] pe;
        pe = (p < 2) ? 32'd2 : p;
        eq.delete();
        eq.push_back('{a: A_CTRL, d: 32'd0});
        eq.push_back('{a: A_CTRL, d: 32'd1});
        for (int i = 0; i < n_loads; i++) eq.push_back('{a: A_LOAD, d: pe});
        eq.push_back('{a: A_CTRL, d: 32'd0});
    endtask

    function automatic int first_diff();
        if (wq.size() != eq.size()) return -2;
        foreach (wq[i]) if (wq[i] !== eq[i]) return i;
        return -1;
    endfunction

    task automatic do_start(input logic [31:0] p, input logic [15:0] r);
        period = p;
        reps   = r;
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit timed_out);
        int k;
        k = 0;
        while (n_done == 0 && k < budget) begin
            step();
            k++;
        end
        timed_out = (n_done == 0);
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        total++;
        if ({busy, tick, done, err, rep_cnt, bus.t_rd_en, bus.t_wr_en} !== '0) begin
            bad++;
            $display("FAIL reset_status got=%b/%b/%b/%b/%h exp=0", busy, tick, done, err, rep_cnt);
        end
        total++;
        if ({bus.t_addr, bus.t_wr_data} !== '0) begin
            bad++;
            $display("FAIL reset_bus got addr=%h data=%h exp=0", bus.t_addr, bus.t_wr_data);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        bit to;
        logic ew, er;
        logic [31:0] ea, ed;
        int diff;
        rdy_rand = 1'b0;
        clr_mon();
        do_start(32'd5, 16'd1);
        for (int k = 1; k <= 4 + SETTLE; k++) begin
            ew = (k <= 3);
            er = (k == 4 + SETTLE);
            ea = (k == 3) ? A_LOAD : (k == 4 + SETTLE) ? A_STAT : A_CTRL;
            ed = (k == 2) ? 32'd1 : (k == 3) ? 32'd5 : 32'd0;
            total++;
            if (bus.t_wr_en !== ew || bus.t_rd_en !== er || bus.t_addr !== ea ||
                (ew && bus.t_wr_data !== ed) || busy !== 1'b1) begin
                bad++;
                $display("FAIL single_latency k=%0d got wr=%b rd=%b addr=%h data=%h busy=%b exp wr=%b rd=%b addr=%h data=%h",
                         k, bus.t_wr_en, bus.t_rd_en, bus.t_addr, bus.t_wr_data, busy, ew, er, ea, ed);
            end
            if (k < 4 + SETTLE) step();
        end
        wait_done(300, to);
        total++;
        if (to) begin bad++; $display("FAIL single_timeout got no done exp done"); end
        build_exp(32'd5, 1);
        diff = first_diff();
        total++;
        if (diff != -1) begin bad++; $display("FAIL single_writes idx=%0d got n=%0d exp n=%0d", diff, wq.size(), eq.size()); end
        total++;
        if (n_tick != 1 || rep_cnt !== 16'd1 || n_done != 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_end got tick=%0d rep=%0d done=%0d busy=%b exp 1/1/1/0", n_tick, rep_cnt, n_done, busy);
        end
    endtask

    task automatic test_repeat();
        bit to;
        int diff;
        clr_mon();
        do_start(32'd4, 16'd3);
        wait_done(600, to);
        total++;
        if (to) begin bad++; $display("FAIL repeat_timeout got no done exp done"); end
        build_exp(32'd4, 3);
        diff = first_diff();
        total++;
        if (diff != -1) begin bad++; $display("FAIL repeat_writes idx=%0d got n=%0d exp n=%0d", diff, wq.size(), eq.size()); end
        total++;
        if (n_tick != 3 || rep_cnt !== 16'd3 || n_done != 1) begin
            bad++;
            $display("FAIL repeat_end got tick=%0d rep=%0d done=%0d exp 3/3/1", n_tick, rep_cnt, n_done);
        end
    endtask

    task automatic test_abort();
        bit to;
        int k, diff;
        rdy_rand = 1'b1;
        clr_mon();
        do_start(32'd3, 16'd0);
        k = 0;
        while ((n_tick < 2 || bus.t_rd_en !== 1'b1) && k < 500) begin step(); k++; end
        total++;
        if (k >= 500) begin bad++; $display("FAIL abort_reach_poll got tick=%0d exp 2 ticks then poll", n_tick); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        total++;
        if (bus.t_wr_en !== 1'b1 || bus.t_addr !== A_CTRL || bus.t_wr_data !== 32'd0) begin
            bad++;
            $display("FAIL abort_disarm got wr=%b addr=%h data=%h exp 1/%h/0", bus.t_wr_en, bus.t_addr, bus.t_wr_data, A_CTRL);
        end
        wait_done(20, to);
        repeat (10) step();
        build_exp(32'd3, 3);
        diff = first_diff();
        total++;
        if (to || diff != -1) begin bad++; $display("FAIL abort_writes to=%b idx=%0d got n=%0d exp n=%0d", to, diff, wq.size(), eq.size()); end
        total++;
        if (n_tick != 2 || rep_cnt !== 16'd2 || n_done != 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_end got tick=%0d rep=%0d done=%0d busy=%b exp 2/2/1/0", n_tick, rep_cnt, n_done, busy);
        end
        rdy_rand = 1'b0;
    endtask

    task automatic test_clamp_ignored();
        bit to;
        int diff;
        clr_mon();
        do_start(32'd0, 16'd1);
        do_start(32'd7, 16'd5);
        wait_done(300, to);
        repeat (10) step();
        build_exp(32'd0, 1);
        diff = first_diff();
        total++;
        if (to || diff != -1) begin bad++; $display("FAIL clamp_writes to=%b idx=%0d got n=%0d exp n=%0d", to, diff, wq.size(), eq.size()); end
        total++;
        if (n_tick != 1 || rep_cnt !== 16'd1 || n_done != 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL ignored_start got tick=%0d rep=%0d done=%0d busy=%b exp 1/1/1/0", n_tick, rep_cnt, n_done, busy);
        end
    endtask

    task automatic test_error();
        bit to;
        int diff;
        clr_mon();
        inj_en = 1'b1;
        do_start(32'd6, 16'd2);
        wait_done(40, to);
        inj_en = 1'b0;
        build_exp(32'd6, 1);
        diff = first_diff();
        total++;
        if (to || diff != -1) begin bad++; $display("FAIL error_writes to=%b idx=%0d got n=%0d exp n=%0d", to, diff, wq.size(), eq.size()); end
        total++;
        if (err !== 1'b1 || n_tick != 0 || n_done != 1) begin
            bad++;
            $display("FAIL error_flag got err=%b tick=%0d done=%0d exp 1/0/1", err, n_tick, n_done);
        end
        clr_mon();
        do_start(32'd2, 16'd1);
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL error_clear got err=%b exp 0", err); end
        wait_done(300, to);
        total++;
        if (to || err !== 1'b0 || n_tick != 1) begin bad++; $display("FAIL error_rerun to=%b got err=%b tick=%0d exp 0/1", to, err, n_tick); end
    endtask

    task automatic test_start_abort_idle();
        clr_mon();
        start = 1'b1;
        abort = 1'b1;
        period = 32'd9;
        reps = 16'd1;
        step();
        start = 1'b0;
        abort = 1'b0;
        repeat (5) step();
        total++;
        if (busy !== 1'b0 || wq.size() != 0) begin
            bad++;
            $display("FAIL start_abort_idle got busy=%b writes=%0d exp 0/0", busy, wq.size());
        end
    endtask

    task automatic test_mid_reset();
        clr_mon();
        do_start(32'd8, 16'd2);
        repeat (4) step();
        rst = 1'b1;
        step();
        total++;
        if ({busy, tick, done, err, rep_cnt, bus.t_rd_en, bus.t_wr_en, bus.t_addr, bus.t_wr_data} !== '0) begin
            bad++;
            $display("FAIL mid_reset_out got busy=%b wr=%b rd=%b addr=%h exp all 0", busy, bus.t_wr_en, bus.t_rd_en, bus.t_addr);
        end
        rst = 1'b0;
        repeat (20) step();
        total++;
        if (n_done != 0 || wq.size() != 3 || busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_quiet got done=%0d writes=%0d busy=%b exp 0/3/0", n_done, wq.size(), busy);
        end
    endtask

    task automatic test_random();
        bit to;
        int diff;
        logic [31:0] p;
        logic [15:0] r;
        rdy_rand = 1'b1;
        for (int it = 0; it < 6; it++) begin
            p = 32'($urandom_range(0, 6));
            r = 16'($urandom_range(1, 3));
            clr_mon();
            do_start(p, r);
            wait_done(800, to);
            build_exp(p, int'(r));
            diff = first_diff();
            total++;
            if (to || diff != -1) begin
                bad++;
                $display("FAIL random_writes it=%0d p=%0d r=%0d to=%b idx=%0d got n=%0d exp n=%0d", it, p, r, to, diff, wq.size(), eq.size());
            end
            total++;
            if (n_tick != int'(r) || rep_cnt !== r || n_done != 1 || err !== 1'b0) begin
                bad++;
                $display("FAIL random_end it=%0d got tick=%0d rep=%0d done=%0d err=%b exp %0d/%0d/1/0", it, n_tick, rep_cnt, n_done, err, r, r);
            end
        end
        rdy_rand = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_repeat();
        test_abort();
        test_clamp_ignored();
        test_error();
        test_start_abort_idle();
        test_mid_reset();
        test_random();
        total++;
        if (both_seen) begin bad++; $display("FAIL strobe_exclusive got both high exp never"); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
